wb_rr_arbiter: RTL

- Round-robin Wishbone arbiter that shares one single-beat Wishbone slave bus between NUM_MASTERS masters (LM32 instruction/data ports, debug/DMA engines).
- Sits between the CPU-side masters and the muxed memory/peripheral bus.
- Replaces fixed two-way priority with fair rotation, abort handling and an optional hung-slave watchdog.

---
 rtl/wb_rr_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one single-beat Wishbone slave bus among NUM_MASTERS masters.
// Latency: request sampled in IDLE cycle n owns the bus (m_cyc=1) in cycle n+1; one dead IDLE cycle between transfers.
// Backpressure: masters are held off by withholding s_ack; the slave stalls a transfer by delaying m_ack.
// Optional feature macro: WB_ARB_TIMEOUT_EN (hung-slave watchdog raising s_err after TIMEOUT_CYCLES).
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      sys_clk,
  input  logic                      resetcpu,
  input  logic [NUM_MASTERS-1:0]    s_cyc,
  input  logic [NUM_MASTERS-1:0]    s_stb,
  input  logic [NUM_MASTERS-1:0]    s_we,
  input  logic [4*NUM_MASTERS-1:0]  s_sel,
  input  logic [32*NUM_MASTERS-1:0] s_adr,
  input  logic [32*NUM_MASTERS-1:0] s_dat_o,
  output logic [31:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]    s_ack,
  output logic [NUM_MASTERS-1:0]    s_err,
  output logic                      m_cyc,
  output logic                      m_stb,
  output logic                      m_we,
  output logic [3:0]                m_sel,
  output logic [31:0]               m_adr,
  output logic [31:0]               m_dat_o,
  input  logic [31:0]               m_dat_i,
  input  logic                      m_ack,
  output logic [NUM_MASTERS-1:0]    grant
);

  localparam int IW = $clog2(NUM_MASTERS);

  // Misconfigured instances are rejected at elaboration rather than misbehaving silently.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q,  last_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          gidx;
  logic                   owner_cyc;
  logic                   tmo_fire;

  // Round-robin pick: first requester scanning last+1, last+2, ... modulo NUM_MASTERS.
  always_comb begin
    pick_oh  = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pick_idx = IW'((int'(last_q) + k) % NUM_MASTERS);
      if (!pick_vld && s_cyc[pick_idx]) begin
        pick_vld          = 1'b1;
        pick_oh[pick_idx] = 1'b1;
      end
    end
  end

  // Encode the one-hot grant back to an index for the last-owner pointer.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  assign owner_cyc = |(grant_q & s_cyc);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog counts BUSY cycles without an ack; IDLE clears it.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == BUSY && !m_ack) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge sys_clk or posedge resetcpu) begin
    if (resetcpu) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  // A late ack in the firing cycle wins over the error.
  assign tmo_fire = (state_q == BUSY) && !m_ack && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign s_err    = grant_q & {NUM_MASTERS{tmo_fire}};
`else
  assign tmo_fire = 1'b0;
  assign s_err    = '0;
`endif

  // Next state: grant on any request in IDLE; release on ack, abort or watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = pick_oh;
        end
      end
      BUSY: begin
        if (m_ack || !owner_cyc || tmo_fire) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and rotation pointer registers.
  always_ff @(posedge sys_clk or posedge resetcpu) begin
    if (resetcpu) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // AND-OR bus mux selected by the registered grant; all zero when nobody owns the bus.
  always_comb begin
    m_we    = 1'b0;
    m_sel   = '0;
    m_adr   = '0;
    m_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_we    = m_we    | (grant_q[i] & s_we[i]);
      m_sel   = m_sel   | ({4{grant_q[i]}}  & s_sel[i*4 +: 4]);
      m_adr   = m_adr   | ({32{grant_q[i]}} & s_adr[i*32 +: 32]);
      m_dat_o = m_dat_o | ({32{grant_q[i]}} & s_dat_o[i*32 +: 32]);
    end
  end

  assign m_cyc   = owner_cyc;
  assign m_stb   = |(grant_q & s_stb);
  assign s_ack   = grant_q & {NUM_MASTERS{m_ack}};
  assign s_dat_i = m_dat_i;
  assign grant   = grant_q;

endmodule
